// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse burst generator: FSM state codes and the
// ceil-log2 helper used to size the phase timer.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  // Smallest r with 2**r >= value; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/pulse_burst_gen_phase_timer.sv
// Loadable down-counter with a zero flag; usable for any fixed-width strobe.
// A load value of L keeps the counter nonzero for L cycles before zero rises.
module phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_burst_gen.sv
// Emits a burst of N fixed-width pulses on pulse_out after a start request,
// with busy/done handshake and a registered count of pulses still to finish.
module pulse_burst_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int HIGH_CYC = 4,
  parameter int LOW_CYC  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  localparam int MAX_CYC = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
  localparam int TMR_W   = clog2(MAX_CYC + 1);
  localparam logic [TMR_W-1:0] HIGH_LOAD = TMR_W'(HIGH_CYC - 1);
  localparam logic [TMR_W-1:0] LOW_LOAD  = TMR_W'(LOW_CYC - 1);

  state_e state_q;
  state_e state_d;

  logic             pulse_out_q;
  logic             pulse_out_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;
  logic [CNT_W-1:0] remaining_q;
  logic [CNT_W-1:0] remaining_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_load_val;
  logic             tmr_zero;

  phase_timer #(
    .W(TMR_W)
  ) u_phase_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pulse_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      pulse_out_q <= pulse_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && (count != '0)) begin
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (tmr_zero) begin
          state_d = LOW;
        end
      end
      LOW: begin
        if (tmr_zero) begin
          state_d = (remaining_q != '0) ? HIGH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so pulse_out/busy line up
  // with the state; the timer reloads on every phase change.
  always_comb begin
    pulse_out_d  = (state_d == HIGH);
    busy_d       = (state_d != IDLE);
    done_d       = 1'b0;
    remaining_d  = remaining_q;
    tmr_load     = (state_d != state_q);
    tmr_load_val = '0;
    if (state_d == HIGH) begin
      tmr_load_val = HIGH_LOAD;
    end else if (state_d == LOW) begin
      tmr_load_val = LOW_LOAD;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            remaining_d = count;
          end
        end
      end
      HIGH: begin
        if (tmr_zero && (remaining_q != '0)) begin
          remaining_d = remaining_q - CNT_W'(1);
        end
      end
      LOW: begin
        if (tmr_zero && (remaining_q == '0)) begin
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign pulse_out = pulse_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Self-checking bench for pulse_burst_gen: an arithmetic burst-timeline model
// checked every cycle, plus directed scenarios with hand-computed values.
module tb_pulse_burst_gen;

  localparam int CNT_W = 4;
  localparam int HC    = 2;
  localparam int LC    = 3;
  localparam int PER   = HC + LC;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] count;
  logic             pulse_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remaining;

  int total = 0;
  int bad   = 0;
  int rises = 0;
  int dones = 0;

  // Model: cycle index k since the last accepted start, and its pulse count n.
  bit m_have = 1'b0;
  int m_n    = 0;
  int m_k    = 0;

  logic [15:0] pat_pulse;
  logic [15:0] pat_busy;
  logic [15:0] pat_done;
  int          pat_rem[16];

  pulse_burst_gen #(
    .CNT_W    (CNT_W),
    .HIGH_CYC (HC),
    .LOW_CYC  (LC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .count     (count),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  function automatic int expBusy();
    return (m_have && (m_k < m_n * PER)) ? 1 : 0;
  endfunction

  function automatic int expPulse();
    return (expBusy() != 0 && (m_k % PER) < HC) ? 1 : 0;
  endfunction

  function automatic int expRem();
    if (expBusy() == 0) return 0;
    return m_n - (m_k / PER) - (((m_k % PER) >= HC) ? 1 : 0);
  endfunction

  function automatic int expDone();
    return (m_have && (m_k == m_n * PER)) ? 1 : 0;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelLoop();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_have = 1'b0;
        m_n    = 0;
        m_k    = 0;
      end else if (expBusy() == 0 && start) begin
        m_have = 1'b1;
        m_n    = int'(count);
        m_k    = 0;
      end else if (m_have && m_k <= m_n * PER) begin
        m_k++;
      end
    end
  endtask

  task automatic compareLoop();
    forever begin
      @(negedge clk);
      checkOutput("model_pulse_out", int'(pulse_out), expPulse());
      checkOutput("model_busy", int'(busy), expBusy());
      checkOutput("model_done", int'(done), expDone());
      checkOutput("model_remaining", int'(remaining), expRem());
    end
  endtask

  task automatic monitorLoop();
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (pulse_out && !prev) rises++;
      if (done) dones++;
      prev = pulse_out;
    end
  endtask

  task automatic waitIdle(input int budget);
    int ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    checkOutput("wait_idle_in_time", ok, 1);
  endtask

  task automatic waitDone(input int budget);
    int ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
    checkOutput("wait_done_in_time", ok, 1);
  endtask

  task automatic applyStimulus(input logic [CNT_W-1:0] n);
    @(negedge clk);
    start = 1'b1;
    count = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int base_r;
    int base_d;
    int ok;
    rst   = 1'b1;
    start = 1'b0;
    count = '0;
    pat_pulse = 16'b1100_0110_0011_0000;
    pat_busy  = 16'b1111_1111_1111_1110;
    pat_done  = 16'b0000_0000_0000_0001;
    pat_rem   = '{3, 3, 2, 2, 2, 2, 2, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    fork
      modelLoop();
      compareLoop();
      monitorLoop();
    join_none

    #1;
    checkOutput("reset_pulse_out", int'(pulse_out), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_remaining", int'(remaining), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // count=3 burst against the hand-written 16-cycle waveform
    applyStimulus(4'd3);
    for (int i = 0; i < 16; i++) begin
      checkOutput("t2_pulse_out", int'(pulse_out), int'(pat_pulse[15-i]));
      checkOutput("t2_busy", int'(busy), int'(pat_busy[15-i]));
      checkOutput("t2_done", int'(done), int'(pat_done[15-i]));
      checkOutput("t2_remaining", int'(remaining), pat_rem[i]);
      @(negedge clk);
    end

    // reset pulse with start held high
    start = 1'b1;
    count = 4'd2;
    #2 rst = 1'b1;
    #1;
    checkOutput("t1_rst_pulse_out", int'(pulse_out), 0);
    checkOutput("t1_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("t1_release_busy", int'(busy), 0);
    checkOutput("t1_release_remaining", int'(remaining), 0);
    @(negedge clk);
    start = 1'b0;
    checkOutput("t1_first_pulse", int'(pulse_out), 1);
    checkOutput("t1_first_remaining", int'(remaining), 2);
    waitIdle(40);

    // count=0: bare done strobe
    applyStimulus(4'd0);
    checkOutput("t3_done", int'(done), 1);
    checkOutput("t3_busy", int'(busy), 0);
    checkOutput("t3_pulse_out", int'(pulse_out), 0);
    @(negedge clk);
    checkOutput("t3_done_gone", int'(done), 0);

    // start during a burst is ignored
    base_r = rises;
    base_d = dones;
    applyStimulus(4'd5);
    repeat (6) @(negedge clk);
    start = 1'b1;
    count = 4'd9;
    repeat (3) @(negedge clk);
    start = 1'b0;
    waitIdle(60);
    @(negedge clk);
    checkOutput("t4_pulses", rises - base_r, 5);
    checkOutput("t4_dones", dones - base_d, 1);

    // max count, then back-to-back start on the done cycle
    base_r = rises;
    base_d = dones;
    applyStimulus(4'd15);
    waitDone(200);
    start = 1'b1;
    count = 4'd1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("t5_no_gap_pulse", int'(pulse_out), 1);
    checkOutput("t5_no_gap_remaining", int'(remaining), 1);
    waitIdle(20);
    @(negedge clk);
    checkOutput("t5_pulses", rises - base_r, 16);
    checkOutput("t5_dones", dones - base_d, 2);

    // reset during the second HIGH phase
    base_r = rises;
    base_d = dones;
    applyStimulus(4'd4);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if ((rises - base_r) >= 2 && pulse_out) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("t6_reached_second_high", ok, 1);
    checkOutput("t6_remaining_before", int'(remaining), 3);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_async_pulse_out", int'(pulse_out), 0);
    checkOutput("t6_async_busy", int'(busy), 0);
    checkOutput("t6_async_remaining", int'(remaining), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t6_no_done", dones - base_d, 0);
    base_r = rises;
    base_d = dones;
    applyStimulus(4'd2);
    waitIdle(30);
    @(negedge clk);
    checkOutput("t6_pulses_after", rises - base_r, 2);
    checkOutput("t6_dones_after", dones - base_d, 1);

    // randomized traffic with occasional resets, checked by the model
    repeat (400) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      count = ($urandom_range(0, 7) == 0) ? 4'd15 : CNT_W'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    start = 1'b0;
    waitIdle(120);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_burst_gen.md
Name: pulse_burst_gen

Overview:
Transmit-side companion to the debounced pulse counter. On a start request it emits exactly N clean, fixed-width pulses on a single output line. N is a CNT_W-bit count. High and low phase widths are long enough to pass the team's debouncer, so a counter on the far end reads back N.
Sits between control logic (switches, test sequencer) and any pulse-counting input.

Parameters:
CNT_W, 4, width of burst count and remaining-count output.
HIGH_CYC, 4, clk cycles pulse_out is held high per pulse (>= 1).
LOW_CYC, 4, clk cycles pulse_out is held low after each pulse (>= 1).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  burst request, sampled on rising edge; honoured only when busy=0
count  input  CNT_W  number of pulses to send, latched when start is accepted
pulse_out  output  1  pulse train, registered
busy  output  1  high while a burst is in progress, registered
done  output  1  one-cycle strobe at end of burst (also for count=0), registered
remaining  output  CNT_W  pulses not yet completed in the current burst, registered

Behaviour:
- Reset (asynchronous, active-high; clock clk): state=IDLE; pulse_out=0, busy=0, done=0, remaining=0; phase timer=0. Reset mid-burst aborts immediately; no done strobe is issued.
- Phase timer width is clog2(max(HIGH_CYC,LOW_CYC)+1). There are no combinational paths from inputs to outputs.
- States: IDLE, HIGH, LOW.
- IDLE with start=1 and count!=0 at edge E0:
  - After E0: state=HIGH, pulse_out=1, busy=1, remaining=count, timer loaded.
- IDLE with start=1 and count=0:
  - After E0: done=1 for exactly one cycle; busy stays 0 and pulse_out stays 0.
- HIGH: pulse_out=1 for exactly HIGH_CYC cycles.
  - Then state=LOW, pulse_out=0, and remaining decrements by 1 on the same edge.
- LOW: pulse_out=0 for exactly LOW_CYC cycles.
  - Then, if remaining!=0: state=HIGH, pulse_out=1.
  - Else: state=IDLE, busy=0, done=1 for one cycle.
- Timing:
  - First pulse rises on the cycle after the accepting edge (latency 1).
  - busy is high for exactly N*(HIGH_CYC+LOW_CYC) cycles.
  - done asserts in the first cycle with busy=0.
- start while busy=1 is ignored; count is not re-sampled.
- start in the same cycle as done (busy=0) is accepted; the next burst starts with no extra gap.
- count=2^CNT_W-1 (max) must complete with no wrap of remaining. remaining never underflows below 0.
- done is never asserted together with busy=1.

Decomposition:
- Shared constants header/package pulse_gen_pkg holds:
  - state encodings IDLE=2'd0, HIGH=2'd1, LOW=2'd2;
  - the clog2 helper used for timer sizing.
- One natural sub-module, phase_timer: a loadable down-counter with a zero flag, reusable for other fixed-width strobes.
- FSM and count logic stay in pulse_burst_gen.

Test Plan:
1. rst pulse mid-simulation with start=1 held -> all outputs 0 while rst is high and on the first clk after release, until start is sampled.
2. HIGH_CYC=2, LOW_CYC=3, start for 1 cycle with count=3:
   - pulse_out pattern 11000 repeated 3 times, starting 1 cycle after the start edge;
   - remaining steps 3->2->1->0 on falling edges;
   - busy high for 15 cycles;
   - done high in cycle 16 only.
3. count=0 with start -> done high for exactly 1 cycle after the edge; busy and pulse_out stay 0.
4. count=5, start re-asserted with count=9 during burst -> exactly 5 pulses emitted; single done.
5. count=15 (max) then start with count=1 on the done cycle -> 15 pulses, done, then 1 pulse immediately after, with no idle gap before its HIGH phase.
6. rst asserted during the 2nd HIGH phase of a count=4 burst:
   - pulse_out drops to 0 asynchronously; no done strobe;
   - a new start with count=2 after release gives exactly 2 pulses.
